stepper_pulse_gen: RTL

//  Turns the CPU-written per-axis speed/direction register words into a timed STEP/DIR pulse train for one stepper driver.
//  One instance per axis (X, Y) sits between the regfile speed/direction outputs and the pin_*Speed/pin_*Dir board pins.

---
 rtl/stepper_pulse_gen_pkg.sv | 20 ++
 rtl/stepper_pulse_gen_sync_2ff.sv | 21 ++
 rtl/stepper_pulse_gen.sv | 125 ++++++++++++
 3 files changed

// File: rtl/stepper_pulse_gen_pkg.sv
// Shared definitions for the per-axis STEP/DIR pulse generator: FSM states,
// direction encoding and default timing constants.
package stepper_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DIR_SETUP  = 2'd1,
        ST_PULSE_HIGH = 2'd2,
        ST_PULSE_LOW  = 2'd3
    } step_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int DEF_PULSE_CYCLES     = 200;
    localparam int DEF_DIR_SETUP_CYCLES = 500;
    localparam int DEF_MIN_PERIOD       = 400;
    localparam int DEF_POS_W            = 32;

endpackage

// File: rtl/stepper_pulse_gen_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (limit switches).
module stepper_pulse_gen_sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync_p0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/stepper_pulse_gen.sv
// STEP/DIR pulse generator for one stepper axis: period control, DIR setup,
// limit-switch inhibit and a signed step-position counter.
module stepper_pulse_gen
    import stepper_pulse_gen_pkg::*;
#(
    parameter int PULSE_CYCLES     = DEF_PULSE_CYCLES,
    parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES,
    parameter int MIN_PERIOD       = DEF_MIN_PERIOD,
    parameter int POS_W            = DEF_POS_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [31:0]             speed,
    input  logic [31:0]             direction,
    input  logic                    limit_fwd,
    input  logic                    limit_rev,
    input  logic                    zero_pos,
    output logic                    step_out,
    output logic                    dir_out,
    output logic                    busy,
    output logic                    limit_block,
    output logic signed [POS_W-1:0] position
);

    localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

    function automatic logic [31:0] clamp_period(input logic [31:0] req,
                                                 input logic [31:0] floor_val);
        return (req < floor_val) ? floor_val : req;
    endfunction

    step_state_t state;
    logic [31:0] cnt;
    logic [31:0] per_cnt;
    logic [31:0] period_clk;
    logic        lim_fwd_s, lim_rev_s, lim_dir;
    logic        active_req, request, step_slot, dir_match;
    logic        go_pulse, go_setup;
    logic        unused_dir_hi;

    stepper_pulse_gen_sync_2ff u_sync_fwd (
        .clock (clock),
        .reset (reset),
        .d     (limit_fwd),
        .q     (lim_fwd_s)
    );

    stepper_pulse_gen_sync_2ff u_sync_rev (
        .clock (clock),
        .reset (reset),
        .d     (limit_rev),
        .q     (lim_rev_s)
    );

    assign unused_dir_hi = ^direction[31:1];
    assign period_clk    = clamp_period(speed, 32'(MIN_PERIOD));
    assign lim_dir       = (direction[0] == DIR_REV) ? lim_rev_s : lim_fwd_s;
    assign active_req    = enable && (speed != '0);
    assign request       = active_req && !lim_dir;
    assign limit_block   = active_req && lim_dir;
    assign busy          = (state != ST_IDLE);
    assign dir_match     = (direction[0] == dir_out);

    // A new step may only be launched from IDLE or once the full period has run out.
    always_comb begin
        step_slot = (state == ST_IDLE) || (state == ST_PULSE_LOW && per_cnt == '0);
        go_setup  = request && step_slot && !dir_match;
        go_pulse  = request && dir_match &&
                    (step_slot || (state == ST_DIR_SETUP && cnt == '0));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            step_out <= 1'b0;
            dir_out  <= DIR_FWD;
            cnt      <= '0;
            per_cnt  <= '0;
            position <= '0;
        end else begin
            if (per_cnt != '0)
                per_cnt <= per_cnt - 32'd1;

            if (go_pulse) begin
                state    <= ST_PULSE_HIGH;
                step_out <= 1'b1;
                cnt      <= 32'(PULSE_CYCLES - 1);
                per_cnt  <= period_clk - 32'd1;
                position <= (dir_out == DIR_REV) ? position - POS_ONE : position + POS_ONE;
            end else if (go_setup) begin
                state   <= ST_DIR_SETUP;
                dir_out <= direction[0];
                cnt     <= 32'(DIR_SETUP_CYCLES - 1);
            end else begin
                case (state)
                    ST_DIR_SETUP: begin
                        if (!request || !dir_match)
                            state <= ST_IDLE;
                        else if (cnt != '0)
                            cnt <= cnt - 32'd1;
                    end
                    ST_PULSE_HIGH: begin
                        if (cnt == '0) begin
                            step_out <= 1'b0;
                            state    <= ST_PULSE_LOW;
                        end else begin
                            cnt <= cnt - 32'd1;
                        end
                    end
                    ST_PULSE_LOW: begin
                        if (per_cnt == '0)
                            state <= ST_IDLE;
                    end
                    default: ;
                endcase
            end

            // Clearing the count takes priority over a step on the same edge.
            if (zero_pos)
                position <= '0;
        end
    end

endmodule
